// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller_pkg
// Purpose  : Shared state, opcode, ALU-command and condition-code definitions
//            for the multicycle controller and its condition logic.
// Revision : 1.0  initial release
// ============================================================================
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;

  localparam logic [1:0] c_op_dp   = 2'b00;
  localparam logic [1:0] c_op_mem  = 2'b01;
  localparam logic [1:0] c_op_br   = 2'b10;
  localparam logic [1:0] c_op_none = 2'b11;

  localparam logic [1:0] c_alu_add = 2'b00;
  localparam logic [1:0] c_alu_sub = 2'b01;
  localparam logic [1:0] c_alu_and = 2'b10;
  localparam logic [1:0] c_alu_orr = 2'b11;

  // funct[4:1] data-processing command codes
  localparam logic [3:0] c_fn_add = 4'b0100;
  localparam logic [3:0] c_fn_sub = 4'b0010;
  localparam logic [3:0] c_fn_and = 4'b0000;
  localparam logic [3:0] c_fn_orr = 4'b1100;
  localparam logic [3:0] c_fn_cmp = 4'b1010;

  localparam logic [3:0] c_cond_eq = 4'b0000;
  localparam logic [3:0] c_cond_ne = 4'b0001;
  localparam logic [3:0] c_cond_cs = 4'b0010;
  localparam logic [3:0] c_cond_cc = 4'b0011;
  localparam logic [3:0] c_cond_mi = 4'b0100;
  localparam logic [3:0] c_cond_pl = 4'b0101;
  localparam logic [3:0] c_cond_vs = 4'b0110;
  localparam logic [3:0] c_cond_vc = 4'b0111;
  localparam logic [3:0] c_cond_hi = 4'b1000;
  localparam logic [3:0] c_cond_ls = 4'b1001;
  localparam logic [3:0] c_cond_ge = 4'b1010;
  localparam logic [3:0] c_cond_lt = 4'b1011;
  localparam logic [3:0] c_cond_gt = 4'b1100;
  localparam logic [3:0] c_cond_le = 4'b1101;
  localparam logic [3:0] c_cond_al = 4'b1110;

  // flags are ordered {N,Z,C,V}; the reserved code 1111 never executes
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v, r;
    {n, z, c, v} = flags;
    case (cond)
      c_cond_eq: r = z;
      c_cond_ne: r = ~z;
      c_cond_cs: r = c;
      c_cond_cc: r = ~c;
      c_cond_mi: r = n;
      c_cond_pl: r = ~n;
      c_cond_vs: r = v;
      c_cond_vc: r = ~v;
      c_cond_hi: r = c & ~z;
      c_cond_ls: r = ~c | z;
      c_cond_ge: r = (n == v);
      c_cond_lt: r = (n != v);
      c_cond_gt: r = ~z & (n == v);
      c_cond_le: r = z | (n != v);
      c_cond_al: r = 1'b1;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_cond_logic.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller_cond_logic
// Purpose  : Condition evaluation and {N,Z,C,V} flag register. Present only
//            when COND_EXEC_EN is defined; otherwise every instruction executes.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_controller_cond_logic
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       flag_upd,
  input  logic       cv_upd,
  output logic       cond_ok
);

`ifdef COND_EXEC_EN
  logic [3:0] r_flags;
  logic       w_cond_ok;

  assign w_cond_ok = cond_eval(cond, r_flags);
  assign cond_ok   = w_cond_ok;

  // N,Z follow every flag-setting op; C,V only arithmetic ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else if (flag_upd && w_cond_ok) begin
      r_flags[3:2] <= alu_flags[3:2];
      if (cv_upd) r_flags[1:0] <= alu_flags[1:0];
    end
  end
`else
  logic w_unused_ok;
  assign w_unused_ok = ^{clk, reset, cond, alu_flags, flag_upd, cv_upd};
  assign cond_ok     = 1'b1;
`endif

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Multicycle ARM-subset main FSM, ALU decode and write gating.
//            Conditional execution enabled by defining COND_EXEC_EN.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       adr_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [1:0] alu_ctl
);

  state_t     r_state;
  logic [1:0] w_dp_ctl;
  logic       w_no_write, w_cv_upd;
  logic       w_next_pc, w_branch, w_reg_w, w_mem_w, w_ir_w, w_exec, w_force_ex;
  logic       w_cond_ok, w_cond_ex, w_nw_eff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      case (r_state)
        FETCH:  r_state <= DECODE;
        DECODE: begin
          case (op)
            c_op_mem:  r_state <= MEMADR;
            c_op_dp:   r_state <= funct[5] ? EXECUTEI : EXECUTER;
            c_op_br:   r_state <= BRANCH;
            c_op_none: r_state <= FETCH;
            default:   r_state <= FETCH;
          endcase
        end
        MEMADR:   r_state <= funct[0] ? MEMRD : MEMWR;
        MEMRD:    r_state <= MEMWB;
        EXECUTER: r_state <= ALUWB;
        EXECUTEI: r_state <= ALUWB;
        default:  r_state <= FETCH;
      endcase
    end
  end

  // Unknown commands run as ADD but never write back
  always_comb begin
    w_dp_ctl   = c_alu_add;
    w_no_write = 1'b1;
    w_cv_upd   = 1'b0;
    case (funct[4:1])
      c_fn_add: begin w_dp_ctl = c_alu_add; w_no_write = 1'b0; w_cv_upd = 1'b1; end
      c_fn_sub: begin w_dp_ctl = c_alu_sub; w_no_write = 1'b0; w_cv_upd = 1'b1; end
      c_fn_and: begin w_dp_ctl = c_alu_and; w_no_write = 1'b0; end
      c_fn_orr: begin w_dp_ctl = c_alu_orr; w_no_write = 1'b0; end
      c_fn_cmp: begin w_dp_ctl = c_alu_sub; w_cv_upd = 1'b1; end
      default:  ;
    endcase
  end

  always_comb begin
    w_next_pc  = 1'b0;
    w_branch   = 1'b0;
    w_reg_w    = 1'b0;
    w_mem_w    = 1'b0;
    w_ir_w     = 1'b0;
    w_exec     = 1'b0;
    w_force_ex = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_ctl    = c_alu_add;
    case (r_state)
      FETCH: begin
        w_ir_w = 1'b1; w_next_pc = 1'b1; w_force_ex = 1'b1;
        alu_src_a = 1'b1; alu_src_b = 2'b10; result_src = 2'b10;
      end
      DECODE: begin
        w_force_ex = 1'b1;
        alu_src_a = 1'b1; alu_src_b = 2'b10; result_src = 2'b10;
      end
      MEMADR:   alu_src_b = 2'b01;
      MEMRD:    adr_src = 1'b1;
      MEMWB:    begin result_src = 2'b01; w_reg_w = 1'b1; end
      MEMWR:    begin adr_src = 1'b1; w_mem_w = 1'b1; end
      EXECUTER: begin alu_ctl = w_dp_ctl; w_exec = 1'b1; end
      EXECUTEI: begin alu_src_b = 2'b01; alu_ctl = w_dp_ctl; w_exec = 1'b1; end
      ALUWB:    w_reg_w = 1'b1;
      BRANCH:   begin alu_src_b = 2'b01; result_src = 2'b10; w_branch = 1'b1; end
      default:  ;
    endcase
  end

  multicycle_controller_cond_logic u_cond_logic (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond),
    .alu_flags (alu_flags),
    .flag_upd  (w_exec & funct[0]),
    .cv_upd    (w_cv_upd),
    .cond_ok   (w_cond_ok)
  );

  // no_write only concerns data-processing; loads always write back
  assign w_nw_eff  = w_no_write & (op == c_op_dp);
  assign w_cond_ex = w_force_ex | w_cond_ok;

  assign pc_write  = ~reset & w_cond_ex & (w_next_pc | w_branch | (w_reg_w & (rd == 4'd15)));
  assign ir_write  = ~reset & w_ir_w;
  assign reg_write = ~reset & w_reg_w & w_cond_ex & ~w_nw_eff;
  assign mem_write = ~reset & w_mem_w & w_cond_ex;
  assign imm_src   = op;
  assign reg_src   = {op == c_op_mem, op == c_op_br};

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Self-checking bench: instruction table, corner sequences and
//            random instructions against a behavioural controller model.
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cond = 4'h0;
  logic [1:0] op = 2'b00;
  logic [5:0] funct = 6'h0;
  logic [3:0] rd = 4'h0;
  logic [3:0] alu_flags = 4'h0;
  logic       pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a;
  logic [1:0] alu_src_b, result_src, imm_src, reg_src, alu_ctl;

  int n_err = 0;
  int n_checks = 0;
  logic [3:0] m_flags = 4'h0;

  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MWR = 5,
                 P_ER = 6, P_EI = 7, P_AWB = 8, P_BR = 9;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .alu_flags(alu_flags), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_write(mem_write), .adr_src(adr_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_src(imm_src), .reg_src(reg_src), .alu_ctl(alu_ctl)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dut_vec();
    return {pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a,
            alu_src_b, result_src, imm_src, reg_src, alu_ctl};
  endfunction

  function automatic logic holds(input logic [3:0] c, input logic [3:0] fl);
`ifdef COND_EXEC_EN
    logic n, z, cy, v;
    {n, z, cy, v} = fl;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
`else
    return (c == c) && (fl == fl);
`endif
  endfunction

  // expected output word for one step of an instruction
  function automatic logic [15:0] model_vec(input int p, input logic [3:0] c,
      input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
    logic [1:0] dpc, sb, rs, ac;
    logic nw, cex, irw, npc, br, rw, mw, adr, sa, pcw, regw, memw;
    dpc = 2'b00; nw = 1'b1;
    if (f[4:1] == 4'b0100) begin dpc = 2'b00; nw = 1'b0; end
    if (f[4:1] == 4'b0010) begin dpc = 2'b01; nw = 1'b0; end
    if (f[4:1] == 4'b0000) begin dpc = 2'b10; nw = 1'b0; end
    if (f[4:1] == 4'b1100) begin dpc = 2'b11; nw = 1'b0; end
    if (f[4:1] == 4'b1010) dpc = 2'b01;
    cex = (p == P_F || p == P_D) ? 1'b1 : holds(c, m_flags);
    {irw, npc, br, rw, mw, adr, sa} = '0;
    sb = 2'b00; rs = 2'b00; ac = 2'b00;
    case (p)
      P_F:   begin irw = 1; npc = 1; sa = 1; sb = 2; rs = 2; end
      P_D:   begin sa = 1; sb = 2; rs = 2; end
      P_MA:  sb = 1;
      P_MR:  adr = 1;
      P_MWB: begin rs = 1; rw = 1; end
      P_MWR: begin adr = 1; mw = 1; end
      P_ER:  ac = dpc;
      P_EI:  begin sb = 1; ac = dpc; end
      P_AWB: rw = 1;
      default: begin sb = 1; rs = 2; br = 1; end
    endcase
    pcw  = cex && (npc || br || (rw && r == 4'd15));
    regw = rw && cex && !(o == 2'b00 && nw);
    memw = mw && cex;
    return {pcw, irw, regw, memw, adr, sa, sb, rs, o, (o == 2'b01), (o == 2'b10), ac};
  endfunction

  task automatic model_flags(input logic [3:0] c, input logic [5:0] f, input logic [3:0] fl);
`ifdef COND_EXEC_EN
    if (f[0] && holds(c, m_flags)) begin
      m_flags[3:2] = fl[3:2];
      if (f[4:1] == 4'b0100 || f[4:1] == 4'b0010 || f[4:1] == 4'b1010) m_flags[1:0] = fl[1:0];
    end
`endif
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); @(negedge clk); #1;
  endtask

  // full per-cycle comparison of one instruction against the model
  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input logic [3:0] fl, input string tag);
    int seq[$];
    cond = c; op = o; funct = f; rd = r; alu_flags = fl;
    #1;
    seq = {P_F, P_D};
    if (o == 2'b01) begin
      seq.push_back(P_MA);
      if (f[0]) begin seq.push_back(P_MR); seq.push_back(P_MWB); end
      else seq.push_back(P_MWR);
    end else if (o == 2'b00) begin
      seq.push_back(f[5] ? P_EI : P_ER);
      seq.push_back(P_AWB);
    end else if (o == 2'b10) begin
      seq.push_back(P_BR);
    end
    foreach (seq[i]) begin
      check($sformatf("%s c%h o%0d f%b step%0d", tag, c, o, f, i), dut_vec(), model_vec(seq[i], c, o, f, r));
      if (seq[i] == P_ER || seq[i] == P_EI) model_flags(c, f, fl);
      step();
    end
  endtask

  typedef struct {
    logic [3:0] c; logic [1:0] o; logic [5:0] f; logic [3:0] r; logic [3:0] fl;
    int n; logic [3:0] wr;
  } vec_t;
  vec_t tbl[11];

  initial begin
    int n;
    logic [15:0] last;
    logic [3:0] rc, rr;
    tbl[0]  = '{4'hE, 2'b00, 6'b001000, 4'd1,  4'h0, 4, 4'b0010}; // ADD
    tbl[1]  = '{4'h1, 2'b00, 6'b001000, 4'd1,  4'h4, 4, 4'b0010}; // ADDNE
    tbl[2]  = '{4'hE, 2'b00, 6'b010101, 4'd0,  4'h0, 4, 4'b0000}; // CMP
    tbl[3]  = '{4'hE, 2'b01, 6'b000001, 4'd2,  4'h0, 5, 4'b0010}; // LDR
    tbl[4]  = '{4'hE, 2'b01, 6'b000000, 4'd2,  4'h0, 4, 4'b0001}; // STR
    tbl[5]  = '{4'hE, 2'b01, 6'b000001, 4'd15, 4'h0, 5, 4'b1010}; // LDR pc
    tbl[6]  = '{4'hE, 2'b10, 6'b000000, 4'd0,  4'h0, 3, 4'b1000}; // B
    tbl[7]  = '{4'hE, 2'b11, 6'b000000, 4'd0,  4'h0, 2, 4'b0000}; // op 11
    tbl[8]  = '{4'hE, 2'b00, 6'b111000, 4'd3,  4'h0, 4, 4'b0010}; // ORR imm
    tbl[9]  = '{4'hE, 2'b00, 6'b000110, 4'd3,  4'h0, 4, 4'b0000}; // unknown
    tbl[10] = '{4'hE, 2'b00, 6'b001000, 4'd15, 4'h0, 4, 4'b1010}; // ADD pc

    #1 reset = 1'b1;
    #2 check("reset_outputs", dut_vec(), {4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, 6'b0});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;

    foreach (tbl[i]) begin
      cond = tbl[i].c; op = tbl[i].o; funct = tbl[i].f; rd = tbl[i].r; alu_flags = tbl[i].fl;
      #1;
      n = 0;
      last = dut_vec();
      do begin
        last = dut_vec();
        n++;
        step();
      end while (!ir_write && n < 8);
      check($sformatf("tbl%0d_states", i), 16'(n), 16'(tbl[i].n));
      check($sformatf("tbl%0d_writes", i), {12'h0, last[15:12]}, {12'h0, tbl[i].wr});
    end

    // SUBS sets Z, then BEQ must take
    run_instr(4'hE, 2'b00, 6'b100101, 4'd1, 4'b0100, "subs");
    run_instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100, "cmp");
    cond = 4'h0; op = 2'b10; funct = 6'h0; rd = 4'd0; #1;
    step(); step();
    check("beq_taken_pcw", {15'h0, pc_write}, 16'h0001);
    step();

    // reset in MEMRD abandons the load and clears flags
    cond = 4'hE; op = 2'b01; funct = 6'b000001; rd = 4'd2; #1;
    step(); step(); step();
    check("memrd_adr_src", {15'h0, adr_src}, 16'h0001);
    reset = 1'b1;
    #1 check("reset_midinstr", dut_vec(), {4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00});
    step();
    check("reset_held", dut_vec(), {4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00});
    @(negedge clk);
    reset = 1'b0;
    m_flags = 4'h0;
    run_instr(4'hE, 2'b01, 6'b000001, 4'd2, 4'h0, "ldr_after_reset");
    cond = 4'h0; op = 2'b10; funct = 6'h0; rd = 4'd0; #1;
    step(); step();
`ifdef COND_EXEC_EN
    check("beq_flags_clear_pcw", {15'h0, pc_write}, 16'h0000);
`else
    check("beq_flags_clear_pcw", {15'h0, pc_write}, 16'h0001);
`endif
    step();

    for (int k = 0; k < 200; k++) begin
      rc = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom);
      rr = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom);
      run_instr(rc, 2'($urandom), 6'($urandom), rr, 4'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
